// File: rtl/seg_leds_pkg.sv
// Shared op codes, segment table and id-width helper for the seg_leds_ctrl display block.
package seg_leds_pkg;

  typedef enum logic [1:0] {
    OP_RAW   = 2'd0,
    OP_HEX   = 2'd1,
    OP_READ  = 2'd2,
    OP_BLINK = 2'd3
  } op_e;

  // Active-high patterns, bit order gfedcba.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned id_w(input int unsigned n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/seg_leds_ctrl_if.sv
// Request/response bundle for seg_leds_ctrl: start/done handshake plus id, op and data.
interface seg_leds_ctrl_if #(
  parameter int unsigned ID_W  = 3,
  parameter int unsigned VAL_W = 10
) ();
  logic             start_port;
  logic [ID_W-1:0]  id;
  logic [1:0]       op;
  logic [VAL_W-1:0] val;
  logic             done_port;
  logic [VAL_W-1:0] rdata;

  modport master (output start_port, id, op, val, input done_port, rdata);
  modport slave  (input start_port, id, op, val, output done_port, rdata);
endinterface

// File: rtl/hex7seg_dec.sv
// Combinational nibble to seven-segment (gfedcba) decoder with optional active-low output.
module hex7seg_dec
  import seg_leds_pkg::*;
#(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = ACT_LOW ? ~SEG_LUT[i_nib] : SEG_LUT[i_nib];
  end
endmodule

// File: rtl/seg_leds_ctrl.sv
// Seven-segment and LED bank controller with start/done handshake and register readback.
// Optional blink support (mask, prescaler, phase) enabled by macro SEG_LEDS_BLINK_EN.
module seg_leds_ctrl
  import seg_leds_pkg::*;
#(
  parameter int unsigned N_HEX       = 4,
  parameter int unsigned LEDR_W      = 10,
  parameter int unsigned LEDG_W      = 8,
  parameter int unsigned VAL_W       = 10,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic                 clock,
  input  logic                 reset,
  seg_leds_ctrl_if.slave       bus,
  output logic [7*N_HEX-1:0]   HEX,
  output logic [LEDR_W-1:0]    LEDR,
  output logic [LEDG_W-1:0]    LEDG
);
  localparam int unsigned     ID_W    = id_w(N_HEX);
  localparam logic [ID_W-1:0] ID_LEDR = ID_W'(N_HEX);
  localparam logic [ID_W-1:0] ID_LEDG = ID_W'(N_HEX + 1);
  localparam logic [6:0]      SEG_BLANK = SEG_ACT_LOW ? 7'h7F : 7'h00;

  logic [6:0]        r_hex [N_HEX];
  logic [LEDR_W-1:0] r_ledr;
  logic [LEDG_W-1:0] r_ledg;
  logic              r_done;
  logic [VAL_W-1:0]  r_rdata;

  logic [6:0]        w_dec;
  logic [6:0]        w_seg_wr;
  logic              w_in_range;
  logic              w_is_write;
  logic [VAL_W-1:0]  w_rd;
  logic [N_HEX+1:0]  w_blank;

  hex7seg_dec #(
    .ACT_LOW (SEG_ACT_LOW)
  ) u_dec (
    .i_nib (bus.val[3:0]),
    .o_seg (w_dec)
  );

  assign w_in_range = (bus.id <= ID_LEDG);
  assign w_is_write = bus.start_port && ((bus.op == OP_RAW) || (bus.op == OP_HEX));
  assign w_seg_wr   = (bus.op == OP_HEX) ? w_dec : bus.val[6:0];

`ifdef SEG_LEDS_BLINK_EN
  localparam int unsigned PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [N_HEX+1:0] r_mask;
  logic [PW-1:0]    r_presc;
  logic             r_phase;

  // Free-running: mask updates never disturb prescaler or phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mask  <= '0;
      r_presc <= '0;
      r_phase <= 1'b1;
    end else begin
      if (r_presc == PW'(BLINK_DIV - 1)) begin
        r_presc <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (bus.start_port && (bus.op == OP_BLINK) && w_in_range) begin
        r_mask[bus.id] <= bus.val[0];
      end
    end
  end

  assign w_blank = r_mask & {(N_HEX + 2){~r_phase}};
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < N_HEX; k++) begin
      if (bus.id == ID_W'(k)) w_rd = VAL_W'(r_hex[k]);
    end
    if (bus.id == ID_LEDR) w_rd = VAL_W'(r_ledr);
    if (bus.id == ID_LEDG) w_rd = VAL_W'(r_ledg);
`ifdef SEG_LEDS_BLINK_EN
    if (w_in_range) w_rd[VAL_W-1] = r_mask[bus.id];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_ledr  <= '0;
      r_ledg  <= '0;
      for (int k = 0; k < N_HEX; k++) r_hex[k] <= '0;
    end else begin
      r_done  <= bus.start_port;
      r_rdata <= (bus.start_port && (bus.op == OP_READ)) ? w_rd : '0;
      if (w_is_write) begin
        for (int k = 0; k < N_HEX; k++) begin
          if (bus.id == ID_W'(k)) r_hex[k] <= w_seg_wr;
        end
        if (bus.id == ID_LEDR) r_ledr <= bus.val[LEDR_W-1:0];
        if (bus.id == ID_LEDG) r_ledg <= bus.val[LEDG_W-1:0];
      end
    end
  end

  assign bus.done_port = r_done;
  assign bus.rdata     = r_rdata;

  always_comb begin
    HEX = '0;
    for (int k = 0; k < N_HEX; k++) begin
      HEX[7*k +: 7] = w_blank[k] ? SEG_BLANK : r_hex[k];
    end
    LEDR = w_blank[N_HEX]     ? '0 : r_ledr;
    LEDG = w_blank[N_HEX + 1] ? '0 : r_ledg;
  end

endmodule
